// File: rtl/reg_write_scoreboard_if.sv
// Issue/writeback/status bundle for the register write scoreboard.
// The slave side is the scoreboard; the master side is the pipeline (or a bench).
interface reg_write_scoreboard_if #(
  parameter int NREGS   = 32,
  parameter int FLAGS_W = 13,
  parameter int TOT_W   = 7
) ();
  logic               issue_valid;
  logic [FLAGS_W-1:0] issue_flags;
  logic [4:0]         issue_rd;
  logic [4:0]         issue_rs1;
  logic [4:0]         issue_rs2;
  logic               issue_accept;
  logic               wb_valid;
  logic [4:0]         wb_rd;
  logic               flush;
  logic               stall;
  logic [NREGS-1:0]   pending_mask;
  logic [TOT_W-1:0]   inflight_total;
  logic               err_underflow;

  modport slave (
    input  issue_valid, issue_flags, issue_rd, issue_rs1, issue_rs2,
    input  wb_valid, wb_rd, flush,
    output issue_accept, stall, pending_mask, inflight_total, err_underflow
  );

  modport master (
    output issue_valid, issue_flags, issue_rd, issue_rs1, issue_rs2,
    output wb_valid, wb_rd, flush,
    input  issue_accept, stall, pending_mask, inflight_total, err_underflow
  );
endinterface

// File: rtl/reg_write_scoreboard.sv
// Register write scoreboard: counts issued-but-not-retired writes per
// architectural register and stalls issue on stale-source reads or when a
// destination's in-flight counter is full. x0 is never tracked.
module reg_write_scoreboard #(
  parameter int NREGS   = 32,
  parameter int CNT_W   = 2,
  parameter int FLAGS_W = 13,
  parameter int TOT_W   = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  reg_write_scoreboard_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NREGS-1:0][CNT_W-1:0] cnt_reg;
  logic [NREGS-1:0][CNT_W-1:0] cnt_next;
  logic [NREGS-1:0]            pending_mask_reg;
  logic [NREGS-1:0]            pending_next;
  logic [TOT_W-1:0]            inflight_total_reg;
  logic [TOT_W-1:0]            inflight_total_next;
  logic                        err_underflow_reg;

  logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
  logic             wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
  logic             haz_rs1, haz_rs2, sat_rd;
  logic             stall, issue_accept;
  logic             do_inc, do_dec, underflow;
  logic             unused_flags;

  // Only bit 0 of the flag vector matters here; the rest belong to other stages.
  assign unused_flags = ^bus.issue_flags[FLAGS_W-1:1];

  assign cnt_rs1 = cnt_reg[bus.issue_rs1];
  assign cnt_rs2 = cnt_reg[bus.issue_rs2];
  assign cnt_rd  = cnt_reg[bus.issue_rd];
  assign cnt_wb  = cnt_reg[bus.wb_rd];

  assign wb_hit_rs1 = bus.wb_valid && (bus.wb_rd == bus.issue_rs1);
  assign wb_hit_rs2 = bus.wb_valid && (bus.wb_rd == bus.issue_rs2);
  assign wb_hit_rd  = bus.wb_valid && (bus.wb_rd == bus.issue_rd);

  // A source retiring its last in-flight write this cycle is bypassed by the
  // regfile, so it does not count as a hazard.
  assign haz_rs1 = (bus.issue_rs1 != 5'd0) && (cnt_rs1 != '0) && !(wb_hit_rs1 && cnt_rs1 == CNT_ONE);
  assign haz_rs2 = (bus.issue_rs2 != 5'd0) && (cnt_rs2 != '0) && !(wb_hit_rs2 && cnt_rs2 == CNT_ONE);
  // A full destination counter is freed by a same-cycle writeback to it.
  assign sat_rd  = bus.issue_flags[0] && (bus.issue_rd != 5'd0) && (cnt_rd == CNT_MAX) && !wb_hit_rd;

  assign stall        = bus.issue_valid && (haz_rs1 || haz_rs2 || sat_rd);
  assign issue_accept = bus.issue_valid && !stall;

  // Flush discards both the issuing write and the retiring one.
  assign do_inc    = issue_accept && bus.issue_flags[0] && (bus.issue_rd != 5'd0) && !bus.flush;
  assign do_dec    = bus.wb_valid && (bus.wb_rd != 5'd0) && (cnt_wb != '0) && !bus.flush;
  assign underflow = bus.wb_valid && (bus.wb_rd != 5'd0) && (cnt_wb == '0) && !bus.flush;

  // Per-register next count; x0 stays at zero forever.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_cnt
    if (gi == 0) begin : g_x0
      assign cnt_next[gi]     = '0;
      assign pending_next[gi] = 1'b0;
    end else begin : g_xn
      logic             inc_hit, dec_hit;
      logic [CNT_W-1:0] nxt;
      assign inc_hit = do_inc && (bus.issue_rd == 5'(gi));
      assign dec_hit = do_dec && (bus.wb_rd == 5'(gi));
      // Increment/decrement, cancelling when both hit the same register.
      always_comb begin
        nxt = cnt_reg[gi];
        if (bus.flush)              nxt = '0;
        else if (inc_hit && !dec_hit) nxt = cnt_reg[gi] + CNT_ONE;
        else if (dec_hit && !inc_hit) nxt = cnt_reg[gi] - CNT_ONE;
      end
      assign cnt_next[gi]     = nxt;
      assign pending_next[gi] = (nxt != '0);
    end
  end

  // Running total moves by at most one per cycle in either direction.
  always_comb begin
    inflight_total_next = inflight_total_reg + TOT_W'(do_inc) - TOT_W'(do_dec);
    if (bus.flush) inflight_total_next = '0;
  end

  // Counter, mask, total and sticky error state; reset beats everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg            <= '0;
      pending_mask_reg   <= '0;
      inflight_total_reg <= '0;
      err_underflow_reg  <= 1'b0;
    end else begin
      cnt_reg            <= cnt_next;
      pending_mask_reg   <= pending_next;
      inflight_total_reg <= inflight_total_next;
      if (underflow) err_underflow_reg <= 1'b1;
    end
  end

  assign bus.stall          = stall;
  assign bus.issue_accept   = issue_accept;
  assign bus.pending_mask   = pending_mask_reg;
  assign bus.inflight_total = inflight_total_reg;
  assign bus.err_underflow  = err_underflow_reg;

endmodule
